// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - state codes, opcodes, strobe bundle and opcode classes for control_unit
package cu_pkg;

   localparam int CU_OPC_W = 5;

   typedef enum logic [3:0] {
      S_RST  = 4'd0,
      T0     = 4'd1,
      T1     = 4'd2,
      T2     = 4'd3,
      T3     = 4'd4,
      T4     = 4'd5,
      T5     = 4'd6,
      T6     = 4'd7,
      T7     = 4'd8,
      S_HALT = 4'd9
   } state_t;

   localparam logic [4:0] OP_LD   = 5'd0;
   localparam logic [4:0] OP_LDI  = 5'd1;
   localparam logic [4:0] OP_ST   = 5'd2;
   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_AND  = 5'd5;
   localparam logic [4:0] OP_OR   = 5'd6;
   localparam logic [4:0] OP_SHR  = 5'd7;
   localparam logic [4:0] OP_SHRA = 5'd8;
   localparam logic [4:0] OP_SHL  = 5'd9;
   localparam logic [4:0] OP_ROR  = 5'd10;
   localparam logic [4:0] OP_ROL  = 5'd11;
   localparam logic [4:0] OP_ADDI = 5'd12;
   localparam logic [4:0] OP_ANDI = 5'd13;
   localparam logic [4:0] OP_ORI  = 5'd14;
   localparam logic [4:0] OP_MUL  = 5'd15;
   localparam logic [4:0] OP_DIV  = 5'd16;
   localparam logic [4:0] OP_NEG  = 5'd17;
   localparam logic [4:0] OP_NOT  = 5'd18;
   localparam logic [4:0] OP_BR   = 5'd19;
   localparam logic [4:0] OP_JR   = 5'd20;
   localparam logic [4:0] OP_IN   = 5'd21;
   localparam logic [4:0] OP_MFHI = 5'd23;
   localparam logic [4:0] OP_MFLO = 5'd24;
   localparam logic [4:0] OP_NOP  = 5'd25;
   localparam logic [4:0] OP_HALT = 5'd26;

   // Address arithmetic for ld/ldi/st/br reuses the ALU adder.
   localparam logic [4:0] ALU_ADD = OP_ADD;

   typedef struct packed {
      logic       pc_enable;
      logic       pc_increment_enable;
      logic       ir_enable;
      logic       con_enable;
      logic       y_enable;
      logic       z_enable;
      logic       mar_enable;
      logic       mdr_enable;
      logic       hi_enable;
      logic       lo_enable;
      logic       read;
      logic       write;
      logic       gra;
      logic       grb;
      logic       grc;
      logic       r_enable;
      logic       r_select;
      logic       ba_out;
      logic       pc_select;
      logic       hi_select;
      logic       lo_select;
      logic       z_hi_select;
      logic       z_lo_select;
      logic       mdr_select;
      logic       inport_select;
      logic       c_select;
      logic [4:0] alu_instruction;
   } strobes_t;

   // Two-register ALU ops: add..rol plus neg/not.
   function automatic logic is_alu_r(input logic [4:0] opc);
      return ((opc >= OP_ADD) && (opc <= OP_ROL)) || (opc == OP_NEG) || (opc == OP_NOT);
   endfunction

   // Register/immediate ALU ops.
   function automatic logic is_alu_i(input logic [4:0] opc);
      return (opc == OP_ADDI) || (opc == OP_ANDI) || (opc == OP_ORI);
   endfunction

   // Ops that form an effective address in T3-T4.
   function automatic logic is_mem(input logic [4:0] opc);
      return (opc == OP_LD) || (opc == OP_LDI) || (opc == OP_ST);
   endfunction

   function automatic logic is_muldiv(input logic [4:0] opc);
      return (opc == OP_MUL) || (opc == OP_DIV);
   endfunction

   // Ops that finish in T3.
   function automatic logic is_short(input logic [4:0] opc);
      return (opc == OP_JR) || (opc == OP_IN) || (opc == OP_MFHI) || (opc == OP_MFLO);
   endfunction

   // Ops that have any execute phase at all.
   function automatic logic is_exec(input logic [4:0] opc);
      return is_alu_r(opc) || is_alu_i(opc) || is_mem(opc) || is_muldiv(opc) ||
             is_short(opc) || (opc == OP_BR);
   endfunction

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - combinational strobe decode from state, opcode and branch condition
module cu_decode
   import cu_pkg::*;
(
   input  state_t     i_state,
   input  logic [4:0] i_opc,
   input  logic       i_con,
   output strobes_t   o_strb
);

   // Moore decode: everything defaults off, each state turns on only its own strobes.
   always_comb begin
      o_strb = '0;
      case (i_state)
         T0: begin
            o_strb.pc_select           = 1'b1;
            o_strb.mar_enable          = 1'b1;
            o_strb.pc_increment_enable = 1'b1;
         end
         T1: begin
            o_strb.read       = 1'b1;
            o_strb.mdr_enable = 1'b1;
         end
         T2: begin
            o_strb.mdr_select = 1'b1;
            o_strb.ir_enable  = 1'b1;
         end
         T3: begin
            if (is_alu_r(i_opc) || is_alu_i(i_opc)) begin
               o_strb.grb      = 1'b1;
               o_strb.r_select = 1'b1;
               o_strb.y_enable = 1'b1;
            end else if (is_mem(i_opc)) begin
               o_strb.grb      = 1'b1;
               o_strb.ba_out   = 1'b1;
               o_strb.y_enable = 1'b1;
            end else if (is_muldiv(i_opc)) begin
               o_strb.gra      = 1'b1;
               o_strb.r_select = 1'b1;
               o_strb.y_enable = 1'b1;
            end else if (i_opc == OP_BR) begin
               o_strb.gra        = 1'b1;
               o_strb.r_select   = 1'b1;
               o_strb.con_enable = 1'b1;
            end else if (i_opc == OP_JR) begin
               o_strb.gra       = 1'b1;
               o_strb.r_select  = 1'b1;
               o_strb.pc_enable = 1'b1;
            end else if (i_opc == OP_MFHI) begin
               o_strb.hi_select = 1'b1;
               o_strb.gra       = 1'b1;
               o_strb.r_enable  = 1'b1;
            end else if (i_opc == OP_MFLO) begin
               o_strb.lo_select = 1'b1;
               o_strb.gra       = 1'b1;
               o_strb.r_enable  = 1'b1;
            end else if (i_opc == OP_IN) begin
               o_strb.inport_select = 1'b1;
               o_strb.gra           = 1'b1;
               o_strb.r_enable      = 1'b1;
            end
         end
         T4: begin
            if (is_alu_r(i_opc) || is_muldiv(i_opc)) begin
               // mul/div take the second operand from Rb, ALU R ops from Rc.
               o_strb.grc             = is_alu_r(i_opc);
               o_strb.grb             = is_muldiv(i_opc);
               o_strb.r_select        = 1'b1;
               o_strb.alu_instruction = i_opc;
               o_strb.z_enable        = 1'b1;
            end else if (is_alu_i(i_opc)) begin
               o_strb.c_select        = 1'b1;
               o_strb.alu_instruction = i_opc;
               o_strb.z_enable        = 1'b1;
            end else if (is_mem(i_opc)) begin
               o_strb.c_select        = 1'b1;
               o_strb.alu_instruction = ALU_ADD;
               o_strb.z_enable        = 1'b1;
            end else if (i_opc == OP_BR) begin
               o_strb.pc_select = 1'b1;
               o_strb.y_enable  = 1'b1;
            end
         end
         T5: begin
            if (is_alu_r(i_opc) || is_alu_i(i_opc) || (i_opc == OP_LDI)) begin
               o_strb.z_lo_select = 1'b1;
               o_strb.gra         = 1'b1;
               o_strb.r_enable    = 1'b1;
            end else if ((i_opc == OP_LD) || (i_opc == OP_ST)) begin
               o_strb.z_lo_select = 1'b1;
               o_strb.mar_enable  = 1'b1;
            end else if (is_muldiv(i_opc)) begin
               o_strb.z_lo_select = 1'b1;
               o_strb.lo_enable   = 1'b1;
            end else if (i_opc == OP_BR) begin
               o_strb.c_select        = 1'b1;
               o_strb.alu_instruction = ALU_ADD;
               o_strb.z_enable        = 1'b1;
            end
         end
         T6: begin
            if (i_opc == OP_LD) begin
               o_strb.read       = 1'b1;
               o_strb.mdr_enable = 1'b1;
            end else if (i_opc == OP_ST) begin
               o_strb.gra        = 1'b1;
               o_strb.r_select   = 1'b1;
               o_strb.mdr_enable = 1'b1;
            end else if (is_muldiv(i_opc)) begin
               o_strb.z_hi_select = 1'b1;
               o_strb.hi_enable   = 1'b1;
            end else if (i_opc == OP_BR) begin
               o_strb.z_lo_select = 1'b1;
               o_strb.pc_enable   = i_con;
            end
         end
         T7: begin
            if (i_opc == OP_LD) begin
               o_strb.mdr_select = 1'b1;
               o_strb.gra        = 1'b1;
               o_strb.r_enable   = 1'b1;
            end else if (i_opc == OP_ST) begin
               o_strb.write = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired Moore sequencer; optional halt state under CU_HALT_EN
module control_unit
   import cu_pkg::*;
#(
   parameter int MEM_WAIT = 1,
   parameter int OPC_W    = CU_OPC_W
)(
   input  logic             clk,
   input  logic             clr,
   input  logic [31:0]      IR_Data,
   input  logic             con_output,
   output logic             PC_enable,
   output logic             PC_increment_enable,
   output logic             IR_enable,
   output logic             con_enable,
   output logic             Y_enable,
   output logic             Z_enable,
   output logic             MAR_enable,
   output logic             MDR_enable,
   output logic             HI_enable,
   output logic             LO_enable,
   output logic             read,
   output logic             write,
   output logic             Gra,
   output logic             Grb,
   output logic             Grc,
   output logic             r_enable,
   output logic             r_select,
   output logic             BAout,
   output logic             PC_select,
   output logic             HI_select,
   output logic             LO_select,
   output logic             Z_HI_select,
   output logic             Z_LO_select,
   output logic             MDR_select,
   output logic             InPort_select,
   output logic             c_select,
   output logic [OPC_W-1:0] alu_instruction,
   output logic [3:0]       state_dbg,
   output logic             run
);

   localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

   state_t     r_state;
   logic [2:0] r_wait;
   logic [4:0] w_opc;
   logic       w_wait_done;
   logic       w_unused;
   strobes_t   w_strb;

   assign w_opc       = IR_Data[31:27];
   assign w_wait_done = (r_wait == WAIT_LAST);
   assign w_unused    = ^IR_Data[26:0];

   // State register and RAM wait counter; the counter is zero on entry to every wait state.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state <= S_RST;
         r_wait  <= 3'd0;
      end else begin
         r_wait <= 3'd0;
         case (r_state)
            S_RST: r_state <= T0;
            T0:    r_state <= T1;
            T1: begin
               if (w_wait_done) r_state <= T2;
               else             r_wait  <= r_wait + 3'd1;
            end
            T2: begin
               if (is_exec(w_opc)) r_state <= T3;
`ifdef CU_HALT_EN
               else if (w_opc == OP_HALT) r_state <= S_HALT;
`else
               else if (w_opc == OP_HALT) r_state <= T0;
`endif
               else r_state <= T0;
            end
            T3: r_state <= is_short(w_opc) ? T0 : T4;
            T4: r_state <= T5;
            T5: begin
               if (is_alu_r(w_opc) || is_alu_i(w_opc) || (w_opc == OP_LDI)) r_state <= T0;
               else                                                         r_state <= T6;
            end
            T6: begin
               if (w_opc == OP_LD) begin
                  if (w_wait_done) r_state <= T7;
                  else             r_wait  <= r_wait + 3'd1;
               end else if (w_opc == OP_ST) begin
                  r_state <= T7;
               end else begin
                  r_state <= T0;
               end
            end
            T7: begin
               if ((w_opc == OP_ST) && !w_wait_done) r_wait  <= r_wait + 3'd1;
               else                                   r_state <= T0;
            end
            S_HALT: r_state <= S_HALT;
            default: r_state <= S_RST;
         endcase
      end
   end

   cu_decode u_decode (
      .i_state (r_state),
      .i_opc   (w_opc),
      .i_con   (con_output),
      .o_strb  (w_strb)
   );

   assign PC_enable           = w_strb.pc_enable;
   assign PC_increment_enable = w_strb.pc_increment_enable;
   assign IR_enable           = w_strb.ir_enable;
   assign con_enable          = w_strb.con_enable;
   assign Y_enable            = w_strb.y_enable;
   assign Z_enable            = w_strb.z_enable;
   assign MAR_enable          = w_strb.mar_enable;
   assign MDR_enable          = w_strb.mdr_enable;
   assign HI_enable           = w_strb.hi_enable;
   assign LO_enable           = w_strb.lo_enable;
   assign read                = w_strb.read;
   assign write               = w_strb.write;
   assign Gra                 = w_strb.gra;
   assign Grb                 = w_strb.grb;
   assign Grc                 = w_strb.grc;
   assign r_enable            = w_strb.r_enable;
   assign r_select            = w_strb.r_select;
   assign BAout               = w_strb.ba_out;
   assign PC_select           = w_strb.pc_select;
   assign HI_select           = w_strb.hi_select;
   assign LO_select           = w_strb.lo_select;
   assign Z_HI_select         = w_strb.z_hi_select;
   assign Z_LO_select         = w_strb.z_lo_select;
   assign MDR_select          = w_strb.mdr_select;
   assign InPort_select       = w_strb.inport_select;
   assign c_select            = w_strb.c_select;
   assign alu_instruction     = OPC_W'(w_strb.alu_instruction);
   assign state_dbg           = r_state;
   assign run                 = (r_state != S_RST) && (r_state != S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized self-checking bench for control_unit against a step-list model
module tb_control_unit;

   localparam int MW = 2;

   localparam int ST_RST = 0, ST_T0 = 1, ST_T1 = 2, ST_T2 = 3, ST_T3 = 4;
   localparam int ST_T4 = 5, ST_T5 = 6, ST_T6 = 7, ST_T7 = 8, ST_HALT = 9;

   localparam logic [25:0] PCE    = 26'd1 << 25;
   localparam logic [25:0] PCI    = 26'd1 << 24;
   localparam logic [25:0] IRE    = 26'd1 << 23;
   localparam logic [25:0] CONE   = 26'd1 << 22;
   localparam logic [25:0] YE     = 26'd1 << 21;
   localparam logic [25:0] ZE     = 26'd1 << 20;
   localparam logic [25:0] MARE   = 26'd1 << 19;
   localparam logic [25:0] MDRE   = 26'd1 << 18;
   localparam logic [25:0] HIE    = 26'd1 << 17;
   localparam logic [25:0] LOE    = 26'd1 << 16;
   localparam logic [25:0] RD     = 26'd1 << 15;
   localparam logic [25:0] WR     = 26'd1 << 14;
   localparam logic [25:0] GRA    = 26'd1 << 13;
   localparam logic [25:0] GRB    = 26'd1 << 12;
   localparam logic [25:0] GRC    = 26'd1 << 11;
   localparam logic [25:0] RE     = 26'd1 << 10;
   localparam logic [25:0] RSEL   = 26'd1 << 9;
   localparam logic [25:0] BAO    = 26'd1 << 8;
   localparam logic [25:0] PCSEL  = 26'd1 << 7;
   localparam logic [25:0] HISEL  = 26'd1 << 6;
   localparam logic [25:0] LOSEL  = 26'd1 << 5;
   localparam logic [25:0] ZHI    = 26'd1 << 4;
   localparam logic [25:0] ZLO    = 26'd1 << 3;
   localparam logic [25:0] MDRSEL = 26'd1 << 2;
   localparam logic [25:0] INSEL  = 26'd1 << 1;
   localparam logic [25:0] CSEL   = 26'd1 << 0;

   logic        clk = 1'b0;
   logic        clr;
   logic [31:0] IR_Data;
   logic        con_output;
   logic PC_enable, PC_increment_enable, IR_enable, con_enable, Y_enable, Z_enable;
   logic MAR_enable, MDR_enable, HI_enable, LO_enable, read, write, Gra, Grb, Grc;
   logic r_enable, r_select, BAout, PC_select, HI_select, LO_select, Z_HI_select;
   logic Z_LO_select, MDR_select, InPort_select, c_select, run;
   logic [4:0] alu_instruction;
   logic [3:0] state_dbg;
   logic [25:0] obs;

   always #5 clk = ~clk;

   control_unit #(.MEM_WAIT(MW), .OPC_W(5)) dut (
      .clk(clk), .clr(clr), .IR_Data(IR_Data), .con_output(con_output),
      .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable),
      .IR_enable(IR_enable), .con_enable(con_enable), .Y_enable(Y_enable),
      .Z_enable(Z_enable), .MAR_enable(MAR_enable), .MDR_enable(MDR_enable),
      .HI_enable(HI_enable), .LO_enable(LO_enable), .read(read), .write(write),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .r_enable(r_enable), .r_select(r_select),
      .BAout(BAout), .PC_select(PC_select), .HI_select(HI_select), .LO_select(LO_select),
      .Z_HI_select(Z_HI_select), .Z_LO_select(Z_LO_select), .MDR_select(MDR_select),
      .InPort_select(InPort_select), .c_select(c_select),
      .alu_instruction(alu_instruction), .state_dbg(state_dbg), .run(run)
   );

   assign obs = {PC_enable, PC_increment_enable, IR_enable, con_enable, Y_enable, Z_enable,
                 MAR_enable, MDR_enable, HI_enable, LO_enable, read, write, Gra, Grb, Grc,
                 r_enable, r_select, BAout, PC_select, HI_select, LO_select, Z_HI_select,
                 Z_LO_select, MDR_select, InPort_select, c_select};

   typedef struct {
      int          st;
      logic [25:0] strb;
      logic [4:0]  alu;
   } step_t;

   step_t exp_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;
   int    n_instr  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic check_out(input string tag, input int st, input logic [25:0] s, input logic [4:0] a);
      check({tag, ".state"}, 32'(state_dbg), 32'(st));
      check({tag, ".strb"}, 32'(obs), 32'(s));
      check({tag, ".alu"}, 32'(alu_instruction), 32'(a));
      check({tag, ".run"}, 32'(run), 32'((st != ST_RST) && (st != ST_HALT)));
   endtask

   function automatic void push(input int st, input logic [25:0] s, input logic [4:0] a);
      step_t e;
      e.st = st; e.strb = s; e.alu = a;
      exp_q.push_back(e);
   endfunction

   // Expected per-cycle step list for one instruction, from fetch to the last execute cycle.
   function automatic void build_expect(input int opc, input logic con);
      bit alur, alui, muldiv;
      alur   = ((opc >= 3) && (opc <= 11)) || (opc == 17) || (opc == 18);
      alui   = (opc >= 12) && (opc <= 14);
      muldiv = (opc == 15) || (opc == 16);
      exp_q.delete();
      push(ST_T0, PCSEL | MARE | PCI, 5'd0);
      for (int i = 0; i < MW; i++) push(ST_T1, RD | MDRE, 5'd0);
      push(ST_T2, MDRSEL | IRE, 5'd0);
      if (alur || alui) begin
         push(ST_T3, GRB | RSEL | YE, 5'd0);
         push(ST_T4, (alur ? (GRC | RSEL) : CSEL) | ZE, 5'(opc));
         push(ST_T5, ZLO | GRA | RE, 5'd0);
      end else if (opc <= 2) begin
         push(ST_T3, GRB | BAO | YE, 5'd0);
         push(ST_T4, CSEL | ZE, 5'd3);
         if (opc == 1) begin
            push(ST_T5, ZLO | GRA | RE, 5'd0);
         end else begin
            push(ST_T5, ZLO | MARE, 5'd0);
            if (opc == 0) begin
               for (int i = 0; i < MW; i++) push(ST_T6, RD | MDRE, 5'd0);
               push(ST_T7, MDRSEL | GRA | RE, 5'd0);
            end else begin
               push(ST_T6, GRA | RSEL | MDRE, 5'd0);
               for (int i = 0; i < MW; i++) push(ST_T7, WR, 5'd0);
            end
         end
      end else if (muldiv) begin
         push(ST_T3, GRA | RSEL | YE, 5'd0);
         push(ST_T4, GRB | RSEL | ZE, 5'(opc));
         push(ST_T5, ZLO | LOE, 5'd0);
         push(ST_T6, ZHI | HIE, 5'd0);
      end else if (opc == 19) begin
         push(ST_T3, GRA | RSEL | CONE, 5'd0);
         push(ST_T4, PCSEL | YE, 5'd0);
         push(ST_T5, CSEL | ZE, 5'd3);
         push(ST_T6, ZLO | (con ? PCE : 26'd0), 5'd0);
      end else if (opc == 20) begin
         push(ST_T3, GRA | RSEL | PCE, 5'd0);
      end else if (opc == 21) begin
         push(ST_T3, INSEL | GRA | RE, 5'd0);
      end else if (opc == 23) begin
         push(ST_T3, HISEL | GRA | RE, 5'd0);
      end else if (opc == 24) begin
         push(ST_T3, LOSEL | GRA | RE, 5'd0);
      end
`ifdef CU_HALT_EN
      if (opc == 26) for (int i = 0; i < 20; i++) push(ST_HALT, 26'd0, 5'd0);
`endif
   endfunction

   // Drives one instruction starting at the edge that enters T0; optionally pulls clr mid-state.
   task automatic run_instr(input logic [31:0] ir, input logic con, input int abort_st);
      string tag;
      build_expect(int'(ir[31:27]), con);
      n_instr++;
      foreach (exp_q[k]) begin
         @(posedge clk); #1;
         if (k == 0) begin
            IR_Data    = ir;
            con_output = con;
         end
         tag = $sformatf("i%0d.op%0d.k%0d", n_instr, ir[31:27], k);
         if (exp_q[k].st == abort_st) begin
            #2 clr = 1'b0;
            #1 check_out({tag, ".abort"}, ST_RST, 26'd0, 5'd0);
            @(negedge clk);
            clr = 1'b1;
            #1 check_out({tag, ".release"}, ST_RST, 26'd0, 5'd0);
            return;
         end
         @(negedge clk);
         check_out(tag, exp_q[k].st, exp_q[k].strb, exp_q[k].alu);
      end
   endtask

   initial begin
      int          o;
      logic [31:0] ir;
      clr        = 1'b0;
      IR_Data    = 32'd0;
      con_output = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_out("reset", ST_RST, 26'd0, 5'd0);
      clr = 1'b1;
      #1 check_out("reset_rel", ST_RST, 26'd0, 5'd0);

      run_instr(32'h1891_8000, 1'b0, ST_T4);
      run_instr(32'h1891_8000, 1'b0, -1);
      run_instr(32'h0090_0054, 1'b0, -1);
      run_instr(32'h9880_0000, 1'b0, -1);
      run_instr(32'h9880_0000, 1'b1, -1);
      run_instr(32'h7891_8000, 1'b0, -1);
      run_instr(32'h1000_0010, 1'b0, -1);

      for (int n = 0; n < 40; n++) begin
         o = int'($urandom_range(0, 31));
`ifdef CU_HALT_EN
         if (o == 26) o = 25;
`endif
         ir = {o[4:0], 27'($urandom)};
         run_instr(ir, 1'($urandom), -1);
      end

      run_instr(32'hD000_0000, 1'b0, -1);
      run_instr(32'h1891_8000, 1'b1, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
